// File: rtl/lvds_rx_sched_if.sv
// Bundles the two deserializer word streams with the RX FIFO write port.
interface lvds_rx_sched_if;
    logic        i_ch0_valid;
    logic [31:0] i_ch0_data;
    logic        i_ch1_valid;
    logic [31:0] i_ch1_data;
    logic        i_fifo_full;
    logic        o_fifo_push;
    logic [31:0] o_fifo_data;

    modport master (
        output i_ch0_valid, i_ch0_data,
        output i_ch1_valid, i_ch1_data,
        output i_fifo_full,
        input  o_fifo_push, o_fifo_data
    );

    modport slave (
        input  i_ch0_valid, i_ch0_data,
        input  i_ch1_valid, i_ch1_data,
        input  i_fifo_full,
        output o_fifo_push, o_fifo_data
    );
endinterface

// File: rtl/lvds_rx_sched.sv
// LVDS RX scheduler: channel select, receiver reset control, sync-loss watchdog.
// Define LVDS_RX_SCHED_TAG_EN to carry the source channel in o_fifo_data[30].
module lvds_rx_sched #(
    parameter int TIMEOUT    = 256,
    parameter int RST_CYCLES = 8,
    parameter int BURST      = 1024,
    parameter int CNT_W      = 16
) (
    input  logic             i_ddr_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_mode,
    input  logic             i_clear_status,
    lvds_rx_sched_if.slave   bus,
    output logic [1:0]       o_rx_reset,
    output logic             o_ch_sel,
    output logic             o_active,
    output logic             o_sync_lost,
    output logic [CNT_W-1:0] o_drop_cnt
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int BU_W = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              sel_q, sel_d;
    logic [WD_W-1:0]   wd_cnt, wd_d;
    logic [RC_W-1:0]   rst_cnt, rst_d;
    logic [BU_W-1:0]   burst_cnt, burst_d;
    logic              set_lost;
    logic              sync_q;
    logic [CNT_W-1:0]  drop_q;
    logic              push_q;
    logic [31:0]       data_q;

    logic              sel_valid;
    logic [31:0]       sel_data;
    logic [31:0]       word;
    logic              running;
    logic              accept;
    logic              drop;
    logic              mode_chg;
    logic              alt;

    assign sel_valid = sel_q ? bus.i_ch1_valid : bus.i_ch0_valid;
    assign sel_data  = sel_q ? bus.i_ch1_data  : bus.i_ch0_data;
    assign running   = (state == S_RUN);
    assign accept    = running && sel_valid && !bus.i_fifo_full;
    assign drop      = running && sel_valid &&  bus.i_fifo_full;
    assign mode_chg  = (i_mode != mode_q);
    assign alt       = (mode_q == 2'b11);

`ifdef LVDS_RX_SCHED_TAG_EN
    assign word = {sel_data[31], sel_q, sel_data[29:0]};
`else
    assign word = sel_data;
`endif

    always_ff @(posedge i_ddr_clk) begin
        if (i_reset) begin
            state     <= S_OFF;
            mode_q    <= 2'b00;
            sel_q     <= 1'b0;
            wd_cnt    <= '0;
            rst_cnt   <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_d;
            mode_q    <= mode_d;
            sel_q     <= sel_d;
            wd_cnt    <= wd_d;
            rst_cnt   <= rst_d;
            burst_cnt <= burst_d;
        end
    end

    always_comb begin
        state_d  = state;
        mode_d   = mode_q;
        sel_d    = sel_q;
        wd_d     = wd_cnt;
        rst_d    = rst_cnt;
        burst_d  = burst_cnt;
        set_lost = 1'b0;
        unique case (state)
            S_OFF: begin
                mode_d = 2'b00;
                if (i_mode != 2'b00) begin
                    mode_d  = i_mode;
                    sel_d   = (i_mode == 2'b10);
                    state_d = S_RESET;
                    rst_d   = '0;
                    wd_d    = '0;
                    burst_d = '0;
                end
            end
            S_RESET, S_RUN: begin
                if (mode_chg) begin
                    // Mode change outranks timeout and burst switching
                    mode_d  = i_mode;
                    rst_d   = '0;
                    wd_d    = '0;
                    burst_d = '0;
                    if (i_mode == 2'b00) begin
                        state_d = S_OFF;
                    end else begin
                        sel_d   = (i_mode == 2'b10);
                        state_d = S_RESET;
                    end
                end else if (state == S_RESET) begin
                    if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        state_d = S_RUN;
                    end else begin
                        rst_d = rst_cnt + 1'b1;
                    end
                end else if (!sel_valid && wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    set_lost = 1'b1;
                    state_d  = S_RESET;
                    rst_d    = '0;
                    wd_d     = '0;
                    burst_d  = '0;
                    if (alt) begin
                        sel_d = ~sel_q;
                    end
                end else begin
                    wd_d = sel_valid ? '0 : wd_cnt + 1'b1;
                    if (accept && alt) begin
                        if (burst_cnt == BU_W'(BURST - 1)) begin
                            sel_d   = ~sel_q;
                            burst_d = '0;
                        end else begin
                            burst_d = burst_cnt + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge i_ddr_clk) begin
        if (i_reset) begin
            push_q <= 1'b0;
            data_q <= '0;
        end else begin
            push_q <= accept;
            if (accept) begin
                data_q <= word;
            end
        end
    end

    // A set event in the same cycle as a clear must win
    always_ff @(posedge i_ddr_clk) begin
        if (i_reset) begin
            sync_q <= 1'b0;
            drop_q <= '0;
        end else begin
            if (set_lost) begin
                sync_q <= 1'b1;
            end else if (i_clear_status) begin
                sync_q <= 1'b0;
            end
            if (i_clear_status) begin
                drop_q <= drop ? CNT_W'(1) : '0;
            end else if (drop && !(&drop_q)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    always_comb begin
        o_rx_reset = 2'b11;
        unique case (state)
            S_OFF:   o_rx_reset = 2'b11;
            S_RESET: o_rx_reset = sel_q ? {1'b1, !alt} : {!alt, 1'b1};
            S_RUN:   o_rx_reset = alt ? 2'b00 : (sel_q ? 2'b01 : 2'b10);
            default: o_rx_reset = 2'b11;
        endcase
    end

    assign bus.o_fifo_push = push_q;
    assign bus.o_fifo_data = data_q;
    assign o_ch_sel        = sel_q;
    assign o_active        = running;
    assign o_sync_lost     = sync_q;
    assign o_drop_cnt      = drop_q;
endmodule

// File: tb/tb_lvds_rx_sched.sv
// Randomized bench for lvds_rx_sched with a behavioural reference model.
module tb_lvds_rx_sched;
    localparam int TIMEOUT    = 32;
    localparam int RST_CYCLES = 8;
    localparam int BURST      = 4;
    localparam int CNT_W      = 4;

    logic             i_ddr_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic [1:0]       i_mode = 2'b00;
    logic             i_clear_status = 1'b0;
    logic [1:0]       o_rx_reset;
    logic             o_ch_sel;
    logic             o_active;
    logic             o_sync_lost;
    logic [CNT_W-1:0] o_drop_cnt;

    lvds_rx_sched_if bus ();

    lvds_rx_sched #(
        .TIMEOUT   (TIMEOUT),
        .RST_CYCLES(RST_CYCLES),
        .BURST     (BURST),
        .CNT_W     (CNT_W)
    ) dut (
        .i_ddr_clk     (i_ddr_clk),
        .i_reset       (i_reset),
        .i_mode        (i_mode),
        .i_clear_status(i_clear_status),
        .bus           (bus.slave),
        .o_rx_reset    (o_rx_reset),
        .o_ch_sel      (o_ch_sel),
        .o_active      (o_active),
        .o_sync_lost   (o_sync_lost),
        .o_drop_cnt    (o_drop_cnt)
    );

    always #5 i_ddr_clk = ~i_ddr_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 off, 1 receiver reset, 2 running
    int          m_phase, m_mode, m_sel, m_left, m_idle, m_burst;
    int          m_sync, m_drop, m_push;
    logic [31:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_mode = 0; m_sel = 0; m_left = 0;
        m_idle = 0; m_burst = 0; m_sync = 0; m_drop = 0;
        m_push = 0; m_data = 0;
    endtask

    task automatic enter_reset_phase();
        m_phase = 1;
        m_left  = RST_CYCLES;
    endtask

    task automatic model_step();
        int          sv, run, acc, drp, lost, md;
        logic [31:0] w;
        if (i_reset) begin
            model_reset();
            return;
        end
        md   = int'(i_mode);
        sv   = m_sel ? int'(bus.i_ch1_valid) : int'(bus.i_ch0_valid);
        w    = m_sel ? bus.i_ch1_data : bus.i_ch0_data;
`ifdef LVDS_RX_SCHED_TAG_EN
        w[30] = m_sel[0];
`endif
        run  = (m_phase == 2);
        acc  = run && sv && !bus.i_fifo_full;
        drp  = run && sv && bus.i_fifo_full;
        lost = 0;
        m_push = acc;
        if (acc) m_data = w;
        if (m_phase == 0) begin
            if (md != 0) begin
                m_mode = md; m_sel = (md == 2); enter_reset_phase();
            end
        end else if (md != m_mode) begin
            m_mode = md;
            if (md == 0) m_phase = 0;
            else begin m_sel = (md == 2); enter_reset_phase(); end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin m_phase = 2; m_idle = 0; m_burst = 0; end
        end else begin
            m_idle = sv ? 0 : m_idle + 1;
            if (m_idle == TIMEOUT) begin
                lost = 1;
                if (m_mode == 3) m_sel ^= 1;
                enter_reset_phase();
            end else if (acc && m_mode == 3) begin
                m_burst++;
                if (m_burst == BURST) begin m_sel ^= 1; m_burst = 0; end
            end
        end
        if (lost) m_sync = 1;
        else if (i_clear_status) m_sync = 0;
        if (i_clear_status) m_drop = drp;
        else if (drp && m_drop < (1 << CNT_W) - 1) m_drop++;
    endtask

    function automatic logic [1:0] exp_rx_reset();
        if (m_phase == 0) return 2'b11;
        if (m_phase == 1) begin
            if (m_mode == 3) return m_sel ? 2'b10 : 2'b01;
            return 2'b11;
        end
        if (m_mode == 3) return 2'b00;
        return m_sel ? 2'b01 : 2'b10;
    endfunction

    task automatic tick();
        @(posedge i_ddr_clk);
        model_step();
        #1;
        check("push", 32'(bus.o_fifo_push), 32'(m_push));
        check("data", bus.o_fifo_data, m_data);
        check("rx_reset", 32'(o_rx_reset), 32'(exp_rx_reset()));
        check("ch_sel", 32'(o_ch_sel), 32'(m_sel));
        check("active", 32'(o_active), 32'(m_phase == 2));
        check("sync_lost", 32'(o_sync_lost), 32'(m_sync));
        check("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
    endtask

    task automatic set_in(input logic v0, input logic v1, input logic full);
        bus.i_ch0_valid = v0;
        bus.i_ch1_valid = v1;
        bus.i_ch0_data  = $urandom();
        bus.i_ch1_data  = $urandom();
        bus.i_fifo_full = full;
    endtask

    initial begin
        int found;
        model_reset();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        i_reset = 1'b0;
        tick();

        // Mode 01, a fixed word every 8 cycles
        i_mode = 2'b01;
        for (int i = 0; i < 64; i++) begin
            set_in(i % 8 == 0, 1'b1, 1'b0);
            if (i % 8 == 0) bus.i_ch0_data = 32'h8000_4000;
            tick();
        end

        // Five drops, clear, then saturation
        for (int i = 0; i < 5; i++) begin set_in(1'b1, 1'b0, 1'b1); tick(); end
        set_in(1'b0, 1'b0, 1'b0);
        check("drop5", 32'(o_drop_cnt), 32'd5);
        i_clear_status = 1'b1; tick(); i_clear_status = 1'b0;
        for (int i = 0; i < 20; i++) begin set_in(1'b1, 1'b0, 1'b1); tick(); end
        check("drop_sat", 32'(o_drop_cnt), 32'((1 << CNT_W) - 1));

        // Mode 10 with ch1 silent drives a watchdog timeout
        i_mode = 2'b10;
        for (int i = 0; i < TIMEOUT + 2 * RST_CYCLES + 4; i++) begin
            set_in(1'b1, 1'b0, 1'b0); tick();
        end
        check("timeout_lost", 32'(o_sync_lost), 32'd1);
        i_clear_status = 1'b1; set_in(1'b0, 1'b1, 1'b0); tick();
        i_clear_status = 1'b0;

        // Mode change on the exact timeout cycle
        i_mode = 2'b01;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            set_in(1'b0, 1'b0, 1'b0); tick();
            if (m_phase == 2 && m_idle == TIMEOUT - 1) found = 1;
        end
        check("coinc_reached", 32'(found), 32'd1);
        i_mode = 2'b10; tick();
        check("coinc_lost", 32'(o_sync_lost), 32'd0);

        // Alternate mode with both streaming, then reset mid-burst
        i_mode = 2'b11;
        for (int i = 0; i < 40; i++) begin set_in(1'b1, 1'b1, 1'b0); tick(); end
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        check("rst_rx_reset", 32'(o_rx_reset), 32'd3);
        i_mode = 2'b00; tick();

        // Randomized segments
        for (int s = 0; s < 60; s++) begin
            int len, p0, p1, pf, pc;
            if ($urandom_range(1, 0) == 1) i_mode = 2'($urandom_range(3, 0));
            len = $urandom_range(80, 10);
            p0  = $urandom_range(2, 0) * 50;
            p1  = $urandom_range(2, 0) * 50;
            pf  = $urandom_range(3, 0) == 0 ? 100 : $urandom_range(1, 0) * 20;
            pc  = $urandom_range(1, 0) * 3;
            for (int i = 0; i < len; i++) begin
                set_in($urandom_range(99, 0) < p0, $urandom_range(99, 0) < p1,
                       $urandom_range(99, 0) < pf);
                i_clear_status = ($urandom_range(99, 0) < pc);
                i_reset = ($urandom_range(299, 0) == 0);
                tick();
            end
            i_reset = 1'b0;
            i_clear_status = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
